// File: rtl/sm_hex_keypad_pkg.sv
// Shared definitions for the hex keypad scanner: FSM encoding, parameter
// defaults and the row priority encoder.
package sm_hex_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int SCAN_DIV_DEFAULT       = 50000;
    localparam int DEBOUNCE_TICKS_DEFAULT = 10;

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sm_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read released.
module sm_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sm_hex_keypad.sv
// 4x4 hex keypad scanner: column scan, press/release debounce on slot ticks,
// and an 8-nibble hex entry accumulator.
module sm_hex_keypad
    import sm_hex_keypad_pkg::*;
#(
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] number
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_TICKS);
    localparam logic [DW-1:0] DB_ONE    = DW'(1);

    logic [3:0]    rows_s;
    logic [CW-1:0] slot;
    logic          tick;

    state_t        state, state_n;
    logic [1:0]    col, col_n;
    logic [1:0]    key_row, key_row_n;
    logic [1:0]    key_col, key_col_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic          accept;
    logic          row_high;

    sm_sync2 #(.WIDTH(4)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) slot <= '0;
        else if (tick) slot <= '0;
        else slot <= slot + CW'(1);
    end

    assign tick     = (slot == SLOT_LAST);
    assign row_high = rows_s[key_row];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            col     <= 2'd0;
            key_row <= 2'd0;
            key_col <= 2'd0;
            dcnt    <= '0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            key_row <= key_row_n;
            key_col <= key_col_n;
            dcnt    <= dcnt_n;
        end
    end

    // All decisions happen on slot ticks; between ticks everything holds.
    always_comb begin
        state_n   = state;
        col_n     = col;
        key_row_n = key_row;
        key_col_n = key_col;
        dcnt_n    = dcnt;
        accept    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (rows_s != 4'hF) begin
                        key_row_n = lowest_low_row(rows_s);
                        key_col_n = col;
                        dcnt_n    = DB_ONE;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!row_high) begin
                        dcnt_n = dcnt + DB_ONE;
                        if (dcnt + DB_ONE == DB_DONE) begin
                            state_n = HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        dcnt_n  = '0;
                        col_n   = col + 2'd1;
                        state_n = SCAN;
                    end
                end
                HELD: begin
                    if (row_high) begin
                        dcnt_n  = DB_ONE;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_high) begin
                        if (dcnt + DB_ONE == DB_DONE) begin
                            dcnt_n  = '0;
                            col_n   = col + 2'd1;
                            state_n = SCAN;
                        end else begin
                            dcnt_n = dcnt + DB_ONE;
                        end
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cols      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            number    <= 32'h0;
        end else begin
            cols      <= ~(4'b0001 << col_n);
            key_valid <= accept;
            if (accept) key_code <= {key_row, key_col};
            if (clear) number <= 32'h0;
            else if (accept) number <= {number[27:0], key_row, key_col};
        end
    end

endmodule
